// File: rtl/reg_write_scoreboard.sv
// ============================================================================
//  Module   : reg_write_scoreboard
//  Purpose  : Per-register in-flight write counters feeding the ID-stage
//             dependence stall, with sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_write_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_en,
    input  logic [REG_W-1:0]    issue_reg,
    input  logic                retire_en,
    input  logic [REG_W-1:0]    retire_reg,
    input  logic                kill_en,
    input  logic [REG_W-1:0]    kill_reg,
    input  logic [REG_W-1:0]    rs_id,
    input  logic [REG_W-1:0]    rt_id,
    input  logic                rt_active,
    output logic [NUM_REGS-1:0] busy,
    output logic                dep_stall,
    output logic [TOT_W-1:0]    inflight,
    output logic                idle,
    output logic                overflow_err,
    output logic                underflow_err
);

    localparam int C_CNT_MAX = (1 << CNT_W) - 1;
    localparam int C_TOT_MAX = (1 << TOT_W) - 1;
    localparam int C_EXT_W   = CNT_W + 2;
    localparam int C_SUM_W   = CNT_W + REG_W + 1;

    logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NUM_REGS-1:0]            w_ovf;
    logic [NUM_REGS-1:0]            w_unf;
    logic [C_SUM_W-1:0]             w_sum;
    logic [TOT_W-1:0]               w_tot_nxt;
    logic [TOT_W-1:0]               r_total;
    logic                           r_overflow;
    logic                           r_underflow;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
            logic [C_EXT_W-1:0] w_up;
            logic [C_EXT_W-1:0] w_dn;
            logic [C_EXT_W-1:0] w_res;
            logic [CNT_W-1:0]   w_nxt;
            logic               w_ovf_r;
            logic               w_unf_r;

            // Net delta applied once: up = cnt + issue, dn = retire + kill.
            always_comb begin
                w_up    = C_EXT_W'(r_cnt[g]) + C_EXT_W'(issue_en && (issue_reg == REG_W'(g)));
                w_dn    = C_EXT_W'(retire_en && (retire_reg == REG_W'(g)))
                        + C_EXT_W'(kill_en && (kill_reg == REG_W'(g)));
                w_res   = w_up - w_dn;
                w_nxt   = w_res[CNT_W-1:0];
                w_ovf_r = 1'b0;
                w_unf_r = 1'b0;
                if (w_up < w_dn) begin
                    w_nxt   = '0;
                    w_unf_r = 1'b1;
                end else if (w_res > C_EXT_W'(C_CNT_MAX)) begin
                    w_nxt   = r_cnt[g];
                    w_ovf_r = 1'b1;
                end
            end

            assign w_cnt_nxt[g] = w_nxt;
            assign w_ovf[g]     = w_ovf_r;
            assign w_unf[g]     = w_unf_r;
            assign busy[g]      = |r_cnt[g];
        end
    endgenerate

    // Total follows the clamped counters, then saturates to the output width.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_sum = w_sum + C_SUM_W'(w_cnt_nxt[i]);
        end
        w_tot_nxt = (w_sum > C_SUM_W'(C_TOT_MAX)) ? TOT_W'(C_TOT_MAX) : TOT_W'(w_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_total     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_total     <= w_tot_nxt;
            r_overflow  <= r_overflow  | (|w_ovf);
            r_underflow <= r_underflow | (|w_unf);
        end
    end

    assign dep_stall     = busy[rs_id] | (rt_active & busy[rt_id]);
    assign inflight      = r_total;
    assign idle          = (r_total == '0);
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_scoreboard.sv
// ============================================================================
//  Module   : tb_reg_write_scoreboard
//  Purpose  : Directed bench for reg_write_scoreboard; expected observations
//             are queued by the driver and compared by a negedge monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_write_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_en = 1'b0, retire_en = 1'b0, kill_en = 1'b0, rt_active = 1'b0;
    logic [2:0] issue_reg = '0, retire_reg = '0, kill_reg = '0, rs_id = '0, rt_id = '0;
    logic [7:0] busy;
    logic       dep_stall, idle, overflow_err, underflow_err;
    logic [3:0] inflight;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        bit         chk;
        logic [7:0] busy;
        logic [3:0] inflight;
        logic       dep;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];

    reg_write_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_en     (issue_en),
        .issue_reg    (issue_reg),
        .retire_en    (retire_en),
        .retire_reg   (retire_reg),
        .kill_en      (kill_en),
        .kill_reg     (kill_reg),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .rt_active    (rt_active),
        .busy         (busy),
        .dep_stall    (dep_stall),
        .inflight     (inflight),
        .idle         (idle),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one queued expectation per cycle, observed mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                cmp(e.name, "busy",      int'(busy),          int'(e.busy));
                cmp(e.name, "inflight",  int'(inflight),      int'(e.inflight));
                cmp(e.name, "idle",      int'(idle),          int'(e.inflight == 4'd0));
                cmp(e.name, "dep_stall", int'(dep_stall),     int'(e.dep));
                cmp(e.name, "overflow",  int'(overflow_err),  int'(e.ovf));
                cmp(e.name, "underflow", int'(underflow_err), int'(e.unf));
            end
        end
    end

    // One cycle: drive inputs just after the rising edge and queue what the
    // monitor must see this cycle (state from earlier edges, comb from these inputs).
    task automatic step(input string nm, input bit chk, input logic rst,
                        input logic ie, input logic [2:0] ir,
                        input logic re, input logic [2:0] rr,
                        input logic ke, input logic [2:0] kr,
                        input logic [2:0] rs, input logic [2:0] rt, input logic rta,
                        input logic [7:0] eb, input logic [3:0] ei,
                        input logic ed, input logic eo, input logic eu);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        issue_en = ie;  issue_reg = ir;
        retire_en = re; retire_reg = rr;
        kill_en = ke;   kill_reg = kr;
        rs_id = rs; rt_id = rt; rt_active = rta;
        e.name = nm; e.chk = chk; e.busy = eb; e.inflight = ei;
        e.dep = ed; e.ovf = eo; e.unf = eu;
        exp_q.push_back(e);
    endtask

    initial begin
        //     name        chk rst  ie ir  re rr  ke kr  rs rt rta  busy   inf  dep ovf unf
        step("rst_hold0",  1, 0,   1, 5,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("rst_hold1",  1, 0,   1, 5,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("rst_hold2",  1, 0,   1, 5,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("rst_rel",    1, 1,   1, 5,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("issue_r5",   1, 1,   0, 0,  0, 0,  0, 0,  0, 0, 0,  8'h20, 1,   0,  0,  0);
        step("async_rst",  1, 0,   0, 0,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("raw_issue",  1, 1,   1, 3,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("raw_rs",     1, 1,   0, 0,  0, 0,  0, 0,  3, 0, 0,  8'h08, 1,   1,  0,  0);
        step("raw_rt_off", 1, 1,   0, 0,  0, 0,  0, 0,  0, 3, 0,  8'h08, 1,   0,  0,  0);
        step("raw_rt_on",  1, 1,   0, 0,  1, 3,  0, 0,  0, 3, 1,  8'h08, 1,   1,  0,  0);
        step("raw_clear",  1, 1,   0, 0,  0, 0,  0, 0,  0, 3, 1,  8'h00, 0,   0,  0,  0);
        step("multi_i1",   1, 1,   1, 2,  0, 0,  0, 0,  2, 2, 1,  8'h00, 0,   0,  0,  0);
        step("multi_i2",   1, 1,   1, 2,  0, 0,  0, 0,  2, 2, 1,  8'h04, 1,   1,  0,  0);
        step("multi_i3",   1, 1,   1, 2,  0, 0,  0, 0,  2, 2, 1,  8'h04, 2,   1,  0,  0);
        step("multi_r1",   1, 1,   0, 0,  1, 2,  0, 0,  0, 0, 0,  8'h04, 3,   0,  0,  0);
        step("multi_r2",   1, 1,   0, 0,  1, 2,  0, 0,  0, 0, 0,  8'h04, 2,   0,  0,  0);
        step("multi_r3",   1, 1,   0, 0,  1, 2,  0, 0,  0, 0, 0,  8'h04, 1,   0,  0,  0);
        step("multi_idle", 1, 1,   1, 4,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("sim_irk",    1, 1,   1, 4,  1, 4,  1, 4,  0, 0, 0,  8'h10, 1,   0,  0,  0);
        step("sim_r6",     1, 1,   1, 6,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("sim_i1r6",   1, 1,   1, 1,  1, 6,  0, 0,  0, 0, 0,  8'h40, 1,   0,  0,  0);
        step("sim_after",  1, 1,   1, 7,  0, 0,  0, 0,  0, 0, 0,  8'h02, 1,   0,  0,  0);
        step("sat_i2",     1, 1,   1, 7,  0, 0,  0, 0,  0, 0, 0,  8'h82, 2,   0,  0,  0);
        step("sat_i3",     1, 1,   1, 7,  0, 0,  0, 0,  0, 0, 0,  8'h82, 3,   0,  0,  0);
        step("sat_i4",     1, 1,   1, 7,  0, 0,  0, 0,  0, 0, 0,  8'h82, 4,   0,  0,  0);
        step("sat_ovf",    1, 1,   0, 0,  1, 0,  0, 0,  0, 0, 0,  8'h82, 4,   0,  1,  0);
        step("sat_unf",    1, 1,   0, 0,  1, 7,  0, 0,  0, 0, 0,  8'h82, 4,   0,  1,  1);
        step("sat_held",   1, 1,   0, 0,  0, 0,  0, 0,  0, 0, 0,  8'h82, 3,   0,  1,  1);
        // Fill every counter to 3 so the true total (24) exceeds the 4-bit inflight.
        for (int i = 0; i < 24; i++) begin
            step("fill",   0, 1,   1, 3'(i % 8), 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        end
        step("tot_sat",    1, 1,   0, 0,  0, 0,  1, 5,  0, 0, 0,  8'hFF, 15,  1,  1,  1);
        step("tot_kill",   1, 1,   0, 0,  0, 0,  0, 0,  0, 0, 0,  8'hFF, 15,  1,  1,  1);
        step("rst_flags",  1, 0,   0, 0,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("dbl_issue",  1, 1,   1, 3,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  0);
        step("dbl_dec",    1, 1,   0, 0,  1, 3,  1, 3,  0, 0, 0,  8'h08, 1,   0,  0,  0);
        step("dbl_clamp",  1, 1,   0, 0,  0, 0,  0, 0,  0, 0, 0,  8'h00, 0,   0,  0,  1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Producer side of the register-dependence information used by the ID-stage stall logic.
- Records every register write an instruction carries when it leaves ID (issue), and clears it on writeback (retire) or squash (kill).
- Exposes per-register busy bits and an Rs/Rt dependence result for the ID stage, so stalls follow the real in-flight write count rather than fixed EX/MEM compares.
- Sits beside the ID/EX pipeline register; one instance per core.

Parameters:
- NUM_REGS, 8, number of architectural registers tracked.
- REG_W, 3, register specifier width; must satisfy 2^REG_W = NUM_REGS.
- CNT_W, 2, per-register in-flight counter width; maximum outstanding writes per register = 2^CNT_W - 1.
- TOT_W, 4, width of the total in-flight count.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- issue_en, input, 1, an instruction with RegWrite=1 leaves ID this cycle.
- issue_reg, input, REG_W, destination register of the issuing instruction.
- retire_en, input, 1, a register write completes in WB this cycle.
- retire_reg, input, REG_W, register written in WB.
- kill_en, input, 1, an issued, not-yet-retired writer is squashed this cycle.
- kill_reg, input, REG_W, destination of the squashed writer.
- rs_id, input, REG_W, Rs of the instruction in ID.
- rt_id, input, REG_W, Rt of the instruction in ID.
- rt_active, input, 1, instruction in ID reads Rt.
- busy, output, NUM_REGS, bit i = 1 when counter i is non-zero.
- dep_stall, output, 1, busy[rs_id] | (rt_active & busy[rt_id]).
- inflight, output, TOT_W, sum of all counters.
- idle, output, 1, inflight == 0.
- overflow_err, output, 1, sticky; an issue hit a saturated counter.
- underflow_err, output, 1, sticky; a retire or kill hit a zero counter.

Behaviour:
- Reset (async, rst_n=0):
  - All counters 0; inflight 0; both error flags 0.
  - busy=0, dep_stall=0, idle=1 for the whole time reset is asserted, including mid-operation.
  - Release is synchronous to the next rising edge.
- State: NUM_REGS counters of CNT_W bits, plus a TOT_W total register and two sticky flags.
- Per edge, for each register r: delta = (issue_en & issue_reg==r) - (retire_en & retire_reg==r) - (kill_en & kill_reg==r), range -2..+1.
- All three events may target the same register in one cycle. Apply the net delta once.
  - Example: counter 1, issue+retire+kill same reg -> counter 0.
- Saturation:
  - Net +1 on a counter at 2^CNT_W-1: counter holds, overflow_err sets.
  - Net decrement below 0: counter clamps at 0, underflow_err sets.
  - Flags clear only on reset.
- inflight is a registered copy of the sum of the counters after the clamps are applied. It is never computed from the raw port deltas. Max 8*3=24 needs 5 bits in general; with the defaults, a total above 15 saturates inflight at 15. Counters stay exact.
- Latency:
  - busy, dep_stall, inflight and idle derive only from registered state.
  - Issue in cycle N raises busy at N+1.
  - Retire in cycle N clears busy at N+1. No same-cycle retire bypass; WB-to-ID forwarding through the register file covers that case.
- dep_stall is combinational from the registered busy and the current rs_id/rt_id/rt_active.
  - Rt is ignored when rt_active=0.
  - rs_id == rt_id is legal and behaves the same as any other pair.
- When ID is stalled, the issuing pipeline must drive issue_en=0. The scoreboard does not gate issue_en with dep_stall.
- Flush of the whole pipeline: the issuing pipeline issues one kill per squashed writer. Two writers are killed over two cycles. The scoreboard has no bulk-clear input.

Test Plan:
- Reset: hold rst_n=0 across 3 edges with issue_en=1 and issue_reg=5 -> busy=8'h00, idle=1, inflight=0. Release, issue r5 once -> busy=8'h20 one cycle after the edge, inflight=1.
- RAW stall: issue r3 at N. At N+1 drive rs_id=3 -> dep_stall=1. Drive rt_id=3, rs_id=0, rt_active=0 -> dep_stall=0. Set rt_active=1 -> dep_stall=1. Retire r3 at N+3 -> dep_stall=0 from N+4.
- Multiple writers: issue r2 on 3 consecutive cycles -> counter 3, inflight=3. Retire r2 twice -> busy[2] stays 1. Third retire -> busy[2]=0, idle=1.
- Simultaneous: counter[4]=1. In one cycle drive issue r4, retire r4, kill r4 -> counter[4]=0, no error flags. Separately, in one cycle drive issue r1 and retire r6, with counter[6]=1 -> busy[1]=1, busy[6]=0, inflight unchanged.
- Saturation: issue r7 four times -> counter holds at 3, overflow_err=1 from the 4th edge+1. Retire r0 at zero -> underflow_err=1, counter[0] stays 0, both flags persist until rst_n=0.
